// File: rtl/act_seq_pkg.sv
// Shared state encoding, default sizing and counter-width helper for the
// activation frame sequencer.
package act_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } seq_state_e;

  localparam int unsigned DEF_IN_W          = 48;
  localparam int unsigned DEF_OUT_W         = 4096;
  localparam int unsigned DEF_FRAME_PIXELS  = 50176;
  localparam int unsigned DEF_FLUSH_CYCLES  = 6272;
  localparam int unsigned DEF_EXP_OUTPUTS   = 1;
  localparam int unsigned DEF_DRAIN_TIMEOUT = 4096;
  localparam int unsigned OUT_CNT_W         = 16;

  // Bits needed to hold 0..n inclusive; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n == 0) ? 1 : 32'($clog2(64'(n) + 64'd1));
  endfunction

endpackage

// File: rtl/act_out_capture.sv
// Registered output-beat forwarding plus the saturating per-frame output count,
// kept apart so the wide data register can be placed near its consumer.
module act_out_capture
  import act_seq_pkg::*;
#(
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr_i,
  input  logic                 busy_i,
  input  logic                 dp_ready_i,
  input  logic [OUT_W-1:0]     dp_out_i,
  output logic                 m_valid_o,
  output logic [OUT_W-1:0]     m_data_o,
  output logic [OUT_CNT_W-1:0] out_count_o
);

  logic                 m_valid_q;
  logic [OUT_W-1:0]     m_data_q;
  logic [OUT_CNT_W-1:0] out_count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      out_count_q <= '0;
    end else begin
      m_valid_q <= dp_ready_i;
      m_data_q  <= dp_out_i;
      if (clr_i) begin
        out_count_q <= '0;
      end else if (dp_ready_i && busy_i && (out_count_q != '1)) begin
        out_count_q <= out_count_q + OUT_CNT_W'(1);
      end
    end
  end

  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;
  assign out_count_o = out_count_q;

endmodule

// File: rtl/act_frame_sequencer.sv
// Drives one inference frame into the accelerator: feeds pixels, injects zero
// flush beats, then waits for the expected output beats or a drain timeout.
module act_frame_sequencer
  import act_seq_pkg::*;
#(
  parameter int unsigned IN_W          = DEF_IN_W,
  parameter int unsigned OUT_W         = DEF_OUT_W,
  parameter int unsigned FRAME_PIXELS  = DEF_FRAME_PIXELS,
  parameter int unsigned FLUSH_CYCLES  = DEF_FLUSH_CYCLES,
  parameter int unsigned EXP_OUTPUTS   = DEF_EXP_OUTPUTS,
  parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_timeout,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_W-1:0]      s_data,
  output logic                 dp_valid,
  output logic [IN_W-1:0]      dp_act,
  input  logic                 dp_ready,
  input  logic [OUT_W-1:0]     dp_out,
  output logic                 m_valid,
  output logic [OUT_W-1:0]     m_data,
  output logic [OUT_CNT_W-1:0] out_count
);

  localparam int unsigned PIX_W = cnt_w(FRAME_PIXELS);
  localparam int unsigned FLS_W = cnt_w(FLUSH_CYCLES);
  localparam int unsigned DRN_W = cnt_w(DRAIN_TIMEOUT);

  seq_state_e       state_q;
  logic [PIX_W-1:0] pix_cnt_q;
  logic [FLS_W-1:0] flush_cnt_q;
  logic [DRN_W-1:0] drain_cnt_q;
  logic             dp_valid_q;
  logic [IN_W-1:0]  dp_act_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             err_timeout_q;

  logic             accept;
  logic             out_clr;
  logic             out_hit;
  logic [OUT_CNT_W:0] out_sum;

  assign s_ready = (state_q == FEED);
  assign accept  = s_valid && s_ready;
  assign out_clr = (state_q == IDLE) && start && !abort;

  // Includes this cycle's beat so a final output beats a coincident timeout.
  assign out_sum = {1'b0, out_count} + (OUT_CNT_W + 1)'(dp_ready);
  assign out_hit = out_sum >= (OUT_CNT_W + 1)'(EXP_OUTPUTS);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      pix_cnt_q     <= '0;
      flush_cnt_q   <= '0;
      drain_cnt_q   <= '0;
      dp_valid_q    <= 1'b0;
      dp_act_q      <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      dp_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              state_q       <= FEED;
              busy_q        <= 1'b1;
              pix_cnt_q     <= '0;
              flush_cnt_q   <= '0;
              drain_cnt_q   <= '0;
              err_timeout_q <= 1'b0;
            end
          end
          FEED: begin
            if (accept) begin
              dp_valid_q <= 1'b1;
              dp_act_q   <= s_data;
              pix_cnt_q  <= pix_cnt_q + PIX_W'(1);
              if (32'(pix_cnt_q) + 32'd1 >= FRAME_PIXELS) begin
                state_q <= (FLUSH_CYCLES == 0) ? DRAIN : FLUSH;
              end
            end
          end
          FLUSH: begin
            dp_valid_q  <= 1'b1;
            dp_act_q    <= '0;
            flush_cnt_q <= flush_cnt_q + FLS_W'(1);
            if (32'(flush_cnt_q) + 32'd1 >= FLUSH_CYCLES) begin
              state_q <= DRAIN;
            end
          end
          DRAIN: begin
            drain_cnt_q <= drain_cnt_q + DRN_W'(1);
            if (out_hit) begin
              state_q      <= DONE;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else if (32'(drain_cnt_q) + 32'd1 >= DRAIN_TIMEOUT) begin
              state_q       <= DONE;
              busy_q        <= 1'b0;
              frame_done_q  <= 1'b1;
              err_timeout_q <= 1'b1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign err_timeout = err_timeout_q;
  assign dp_valid    = dp_valid_q;
  assign dp_act      = dp_act_q;

  act_out_capture #(
    .OUT_W (OUT_W)
  ) u_out_capture (
    .clk         (clk),
    .rstn        (rstn),
    .clr_i       (out_clr),
    .busy_i      (busy_q),
    .dp_ready_i  (dp_ready),
    .dp_out_i    (dp_out),
    .m_valid_o   (m_valid),
    .m_data_o    (m_data),
    .out_count_o (out_count)
  );

endmodule

// File: doc/act_frame_sequencer.md
Name: act_frame_sequencer

Overview:
- Sequences one inference frame through the generated accelerator `top`.
- Accepts input activations from an upstream valid/ready stream and drives them into `top`'s valid/input_act port.
- After the last pixel, injects FLUSH_CYCLES zero-activation beats with valid=1 so the pipeline drains.
- Counts `top`'s ready-qualified output beats, forwards them downstream, and signals frame completion or a drain timeout.

Parameters:
- IN_W, 48, input activation width: 3 channels x 16 bits.
- OUT_W, 4096, output activation width: 256 x 16 bits.
- FRAME_PIXELS, 50176, input beats per frame (224x224).
- FLUSH_CYCLES, 6272, zero beats injected after the last pixel.
- EXP_OUTPUTS, 1, output beats expected per frame.
- DRAIN_TIMEOUT, 4096, idle drain cycles before error.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE.
- abort  in  1  forces return to IDLE.
- busy  out  1  high in FEED, FLUSH and DRAIN.
- frame_done  out  1  one-cycle pulse on completion.
- err_timeout  out  1  sticky drain-timeout flag; cleared by start.
- s_valid  in  1  upstream activation valid.
- s_ready  out  1  upstream ready.
- s_data  in  IN_W  upstream activation.
- dp_valid  out  1  to top.valid.
- dp_act  out  IN_W  to top.input_act.
- dp_ready  in  1  from top.ready (output beat valid).
- dp_out  in  OUT_W  from top.output_act.
- m_valid  out  1  downstream output valid; no backpressure.
- m_data  out  OUT_W  downstream output data.
- out_count  out  16  outputs seen in the current frame.

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE; every counter=0; dp_valid=0; dp_act=0; m_valid=0; m_data=0; s_ready=0; busy=0; frame_done=0; err_timeout=0. Reset mid-frame abandons the frame with no frame_done.
- s_ready is combinational: (state==FEED). A beat is accepted when s_valid && s_ready.
- dp_valid/dp_act are registered, so the datapath sees data one cycle after acceptance.
- Cycles with no accepted beat drive dp_valid=0; dp_act holds its last value.
- IDLE: start -> FEED, clearing pix_cnt, flush_cnt, out_count, drain_cnt and err_timeout.
- FEED: each accepted beat gives dp_valid<=1, dp_act<=s_data, pix_cnt++.
  - When the accepted beat takes pix_cnt to FRAME_PIXELS, go to FLUSH next cycle; s_ready is 0 from that cycle.
- FLUSH: dp_valid<=1, dp_act<=0 every cycle, flush_cnt++.
  - After exactly FLUSH_CYCLES beats, go to DRAIN.
  - FLUSH_CYCLES=0 skips straight to DRAIN.
- DRAIN: dp_valid<=0, drain_cnt++ each cycle.
  - out_count reaching EXP_OUTPUTS -> DONE.
  - drain_cnt reaching DRAIN_TIMEOUT first -> DONE with err_timeout<=1.
  - If the final output and the timeout land in the same cycle, the output wins and no error is raised.
- DONE: frame_done=1 for one cycle, then IDLE.
  - The exit is direct when out_count already reaches EXP_OUTPUTS during FEED or FLUSH: the frame finishes its FEED/FLUSH sequence, then DRAIN exits on its first cycle.
- Output path: m_valid<=dp_ready and m_data<=dp_out, registered, in every state (1-cycle latency).
  - out_count increments on dp_ready only while busy and saturates at 16'hFFFF.
  - Beats beyond EXP_OUTPUTS are forwarded and counted but do not change state.
- abort: from any non-IDLE state, go to IDLE next cycle with dp_valid<=0 and no frame_done. Abort has priority over start and over all state transitions.
- Counter widths: $clog2(param+1). Zero flush data is a literal '0 of IN_W.

Decomposition:
- Package act_seq_pkg holds:
  - the state enum (IDLE, FEED, FLUSH, DRAIN, DONE);
  - default width/count localparams;
  - a function computing counter widths.
- One sub-module, act_out_capture: the registered m_valid/m_data path plus the saturating out_count. It keeps the 4096-bit register isolated for timing.
- The FSM and the feed/flush/drain counters stay in the top level.

Test Plan (FRAME_PIXELS=4, FLUSH_CYCLES=3, EXP_OUTPUTS=2, DRAIN_TIMEOUT=8 unless noted):
- Reset then start, 4 back-to-back s_valid beats 1..4 -> dp_act 1,2,3,4 each with dp_valid one cycle later; then 3 cycles of dp_valid=1, dp_act=0; busy=1 throughout; s_ready=0 after the 4th accept.
- Upstream bubbles (s_valid 1,0,0,1,1,0,1) -> exactly 4 dp_valid=1 data beats; dp_valid=0 on bubble cycles; pix_cnt ends at 4.
- dp_ready pulses at flush cycle 2 and drain cycle 3 -> m_valid one cycle later each time; out_count=2; frame_done pulses once; err_timeout=0; then IDLE.
- No dp_ready after start -> 8 drain cycles, then frame_done with err_timeout=1. A subsequent start clears err_timeout.
- Second output arrives in the same cycle the drain counter hits 8 -> frame_done with err_timeout=0.
- Interruptions:
  - abort during FEED after 2 beats -> next cycle IDLE, dp_valid=0, no frame_done.
  - rstn=0 mid-FLUSH -> all outputs zero on the next edge.
  - start while busy -> ignored.
